// File: rtl/rv_defs.sv
// Shared RV definitions used by fetch, mainmem and decode: memory
// window, read/write encoding and the fetch FSM state type.
package rv_defs;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [31:0] STARTING_ADDR   = 32'h0100_0000;
  localparam logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  // Word-aligned and inside [base, base+depth-4].
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] depth);
    return (addr[1:0] == 2'b00) && (addr >= base) && (addr <= base + depth - 32'd4);
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Small power-of-two FIFO holding {pc, instruction} pairs; flush wins
// over push/pop, head is a combinational read of the entry at rd_ptr.
module inst_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DATA_W-1:0]          head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives mainmem with the fetch PC, buffers {pc, word}
// pairs for decode, handles redirects and raises a sticky fetch fault.
module fetch_unit #(
  parameter logic [31:0] STARTING_ADDR   = rv_defs::STARTING_ADDR,
  parameter logic [31:0] MEM_DEPTH_BYTES = rv_defs::MEM_DEPTH_BYTES,
  parameter int          FIFO_DEPTH      = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] mem_address,
  output logic        mem_read_write,
  input  logic [31:0] mem_data_in,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  import rv_defs::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state;
  fetch_state_e     state_nxt;
  logic [31:0]      fetch_pc;
  logic [31:0]      pc_plus4;
  logic [CNT_W-1:0] count;
  logic [63:0]      head;
  logic             push;
  logic             pop;
  logic             flush;
  logic             redirect_bad;
  logic             end_of_window;

  assign pc_plus4       = fetch_pc + 32'd4;
  assign redirect_bad   = !addr_legal(redirect_pc, STARTING_ADDR, MEM_DEPTH_BYTES);
  assign end_of_window  = !addr_legal(pc_plus4, STARTING_ADDR, MEM_DEPTH_BYTES);
  assign inst_valid     = (count != '0) && (state != IDLE);
  assign pop            = inst_valid && inst_ready;
  assign mem_address    = fetch_pc;
  assign mem_read_write = READ;
  assign fetch_fault    = (state == FAULT);
  assign inst_data      = head[31:0];
  assign inst_pc        = head[63:32];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN: begin
        if (redirect_valid) begin
          if (redirect_bad) state_nxt = FAULT;
        end else if (push && end_of_window) begin
          state_nxt = FAULT;
        end
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  // Only RUN moves data into the buffer; a redirect flushes instead of pushing.
  always_comb begin
    flush = 1'b0;
    push  = 1'b0;
    if (state == RUN) begin
      if (redirect_valid) flush = 1'b1;
      else                push  = (count < CNT_W'(FIFO_DEPTH)) || pop;
    end
  end

  // On reaching the window end the last legal word is pushed but the PC holds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= STARTING_ADDR;
      fault_pc <= '0;
    end else if (state == RUN) begin
      if (redirect_valid) begin
        if (redirect_bad) fault_pc <= redirect_pc;
        else              fetch_pc <= redirect_pc;
      end else if (push) begin
        if (end_of_window) fault_pc <= pc_plus4;
        else               fetch_pc <= pc_plus4;
      end
    end
  end

  inst_fifo #(
    .DATA_W (64),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data ({fetch_pc, mem_data_in}),
    .count   (count),
    .head    (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational memory model.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] mem_address;
  logic        mem_read_write;
  logic [31:0] mem_data_in;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] words [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};

  fetch_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .mem_address    (mem_address),
    .mem_read_write (mem_read_write),
    .mem_data_in    (mem_data_in),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h01000000: return 32'h00000013;
      32'h01000004: return 32'h00100093;
      32'h01000008: return 32'h00200113;
      32'h0100000C: return 32'h00300193;
      default:      return ~a;
    endcase
  endfunction

  assign mem_data_in = mem_word(mem_address);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #12;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", inst_data); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", inst_pc); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fetch_fault); end
    checks++; if (fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault_pc: got %h expected 00000000", fault_pc); end
    checks++; if (mem_address !== 32'h01000000) begin errors++; $display("FAIL reset_addr: got %h expected 01000000", mem_address); end
    checks++; if (mem_read_write !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b expected 0", mem_read_write); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_stream();
    inst_ready = 1'b1;
    tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_idle_valid: got %b expected 0", inst_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, inst_valid); end
      checks++; if (inst_pc !== 32'h01000000 + 32'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, inst_pc, 32'h01000000 + 32'(4 * k)); end
      checks++; if (inst_data !== words[k]) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", k, inst_data, words[k]); end
      checks++; if (mem_read_write !== 1'b0) begin errors++; $display("FAIL stream_rw[%0d]: got %b expected 0", k, mem_read_write); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    inst_ready = 1'b0;
    repeat (6) tick();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", inst_valid); end
    checks++; if (mem_address !== 32'h01000008) begin errors++; $display("FAIL stall_fetch_pc: got %h expected 01000008", mem_address); end
    checks++; if (inst_pc !== 32'h01000000) begin errors++; $display("FAIL stall_head_pc: got %h expected 01000000", inst_pc); end
    checks++; if (inst_data !== words[0]) begin errors++; $display("FAIL stall_head_data: got %h expected %h", inst_data, words[0]); end
    inst_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      tick();
      checks++; if (inst_pc !== 32'h01000000 + 32'(4 * k)) begin errors++; $display("FAIL drain_pc[%0d]: got %h expected %h", k, inst_pc, 32'h01000000 + 32'(4 * k)); end
      checks++; if (inst_data !== words[k]) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", k, inst_data, words[k]); end
    end
  endtask

  task automatic test_redirect_full();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h01000100;
    inst_ready     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid: got %b expected 0", inst_valid); end
    checks++; if (mem_address !== 32'h01000100) begin errors++; $display("FAIL redir_fetch_pc: got %h expected 01000100", mem_address); end
    tick();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL redir_valid: got %b expected 1", inst_valid); end
    checks++; if (inst_pc !== 32'h01000100) begin errors++; $display("FAIL redir_pc: got %h expected 01000100", inst_pc); end
    checks++; if (inst_data !== 32'hFEFFFEFF) begin errors++; $display("FAIL redir_data: got %h expected FEFFFEFF", inst_data); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h01000102;
    tick();
    redirect_valid = 1'b0;
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL misal_fault: got %b expected 1", fetch_fault); end
    checks++; if (fault_pc !== 32'h01000102) begin errors++; $display("FAIL misal_fault_pc: got %h expected 01000102", fault_pc); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL misal_valid: got %b expected 0", inst_valid); end
    checks++; if (mem_address !== 32'h01000104) begin errors++; $display("FAIL misal_fetch_pc: got %h expected 01000104", mem_address); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h01000200;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fault_no_push: got %b expected 0", inst_valid); end
    checks++; if (mem_address !== 32'h01000104) begin errors++; $display("FAIL fault_frozen_pc: got %h expected 01000104", mem_address); end
    checks++; if (fault_pc !== 32'h01000102) begin errors++; $display("FAIL fault_sticky_pc: got %h expected 01000102", fault_pc); end
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b expected 1", fetch_fault); end
  endtask

  task automatic test_window_end();
    do_reset();
    inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h010FFFF8;
    tick();
    redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL end_flush_valid: got %b expected 0", inst_valid); end
    checks++; if (mem_address !== 32'h010FFFF8) begin errors++; $display("FAIL end_fetch_pc: got %h expected 010FFFF8", mem_address); end
    tick();
    checks++; if (inst_pc !== 32'h010FFFF8) begin errors++; $display("FAIL end_pc0: got %h expected 010FFFF8", inst_pc); end
    checks++; if (inst_data !== 32'hFEF00007) begin errors++; $display("FAIL end_data0: got %h expected FEF00007", inst_data); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL end_early_fault: got %b expected 0", fetch_fault); end
    tick();
    checks++; if (inst_pc !== 32'h010FFFFC) begin errors++; $display("FAIL end_pc1: got %h expected 010FFFFC", inst_pc); end
    checks++; if (inst_data !== 32'hFEF00003) begin errors++; $display("FAIL end_data1: got %h expected FEF00003", inst_data); end
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL end_fault: got %b expected 1", fetch_fault); end
    checks++; if (fault_pc !== 32'h01100000) begin errors++; $display("FAIL end_fault_pc: got %h expected 01100000", fault_pc); end
    checks++; if (mem_address !== 32'h010FFFFC) begin errors++; $display("FAIL end_frozen_pc: got %h expected 010FFFFC", mem_address); end
    tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL end_drained: got %b expected 0", inst_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    inst_ready = 1'b0;
    repeat (3) tick();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b expected 1", inst_valid); end
    checks++; if (mem_address !== 32'h01000008) begin errors++; $display("FAIL areset_pre_pc: got %h expected 01000008", mem_address); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", inst_valid); end
    checks++; if (mem_address !== 32'h01000000) begin errors++; $display("FAIL areset_addr: got %h expected 01000000", mem_address); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL areset_inst_pc: got %h expected 00000000", inst_pc); end
    checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL areset_inst_data: got %h expected 00000000", inst_data); end
    checks++; if (mem_read_write !== 1'b0) begin errors++; $display("FAIL areset_rw: got %b expected 0", mem_read_write); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_misaligned();
    test_window_end();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of mainmem.
- Drives mainmem's address and read_write inputs with the fetch PC and captures the 32-bit word mainmem returns combinationally.
- Buffers fetched words, each paired with its PC, in a 2-entry FIFO and presents them to decode through a valid/ready handshake.
- Accepts PC redirects from execute and raises a sticky fault on misaligned or out-of-range fetch addresses.

Parameters:
- STARTING_ADDR, 'h01000000, reset PC and base of the memory window.
- MEM_DEPTH_BYTES, 'h0100000, size of the legal fetch window in bytes.
- FIFO_DEPTH, 2, instruction buffer entries; fixed at 2, a power of two is required.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- mem_address  output  32  fetch address to mainmem; equals fetch_pc.
- mem_read_write  output  1  constant READ (0); this block never writes memory.
- mem_data_in  input  32  word returned by mainmem for mem_address, valid in the same cycle.
- inst_valid  output  1  FIFO head holds a valid instruction.
- inst_ready  input  1  decode accepts the head this cycle.
- inst_data  output  32  instruction word at the FIFO head.
- inst_pc  output  32  PC of inst_data.
- redirect_valid  input  1  execute requests a PC change.
- redirect_pc  input  32  new fetch PC.
- fetch_fault  output  1  sticky fault flag.
- fault_pc  output  32  offending PC, captured when fetch_fault sets.

Behaviour:
Reset (async assert, sync release):
- fetch_pc=STARTING_ADDR, FIFO count=0, rd_ptr=wr_ptr=0, state=IDLE.
- inst_valid=0, inst_data=0, inst_pc=0, fetch_fault=0, fault_pc=0.
- mem_read_write=0 at all times, including during reset.

States:
- IDLE: entered from reset; lasts one cycle, no push. Covers mainmem settling after reset release. Next state is RUN.
- RUN: normal fetching.
- FAULT: terminal; exited only by reset.

RUN, per posedge, in priority order:
1. redirect_valid=1:
   - Flush the FIFO (count=0, pointers=0), discarding any head being popped this cycle.
   - If redirect_pc[1:0]!=0, or redirect_pc is outside [STARTING_ADDR, STARTING_ADDR+MEM_DEPTH_BYTES-4]: state=FAULT, fault_pc=redirect_pc, fetch_fault=1.
   - Otherwise fetch_pc=redirect_pc. No push this cycle.
2. Pop: inst_valid && inst_ready removes the head.
3. Push: if count<FIFO_DEPTH, or a pop occurs this cycle, write {fetch_pc, mem_data_in} at wr_ptr, then fetch_pc+=4 (32-bit wrap).
   - Before pushing, if fetch_pc+4 would leave the window, do not advance; enter FAULT after pushing the last legal word. fault_pc=fetch_pc+4.
   - Simultaneous push and pop when full is allowed; count is unchanged.
   - Push without pop: count+1. Pop without push: count-1.

Outputs:
- inst_valid = (count!=0) && state!=IDLE.
- inst_data and inst_pc come from the entry at rd_ptr (registered storage, combinational select).

FAULT:
- No further pushes; fetch_pc frozen.
- The FIFO drains normally to decode.
- Redirects are ignored.

General:
- mem_address = fetch_pc, combinational from the register.
- Reset asserted mid-operation clears everything immediately, regardless of clock.
- Latency: a word is fetched at edge N and visible on inst_data after edge N. The first instruction after reset appears after the 2nd posedge.

Decomposition:
- Shared package (rv_defs): READ/WRITE constants, STARTING_ADDR, MEM_DEPTH_BYTES, state encoding (IDLE=0, RUN=1, FAULT=2). The package is also used by mainmem and decode.
- One natural sub-module, inst_fifo: a 2-entry, 64-bit-wide FIFO with push, pop, flush, count, head outputs and async active-low reset.
- fetch_unit contains the FSM, PC logic and bounds checks.

Test Plan:
- Reset then inst_ready=1 constantly, memory words 0..3 = 'h00000013,'h00100093,'h00200113,'h00300193:
  - inst_pc sequence 01000000, 01000004, 01000008, 0100000C, one per cycle, starting after the 2nd posedge.
  - inst_data matches the words in order.
- inst_ready=0 for 5 cycles:
  - count saturates at 2 and fetch_pc stops at 01000008.
  - On ready=1, PCs 01000000, 01000004, 01000008 are delivered in order, with no duplicates or gaps.
- Redirect to 01000100 while FIFO is full and inst_ready=1 in the same cycle:
  - inst_valid=0 the next cycle.
  - The next delivered inst_pc=01000100.
- Redirect to 01000102: fetch_fault=1, fault_pc=01000102, no further pushes.
- Redirect to 010FFFF8, inst_ready=1:
  - PCs 010FFFF8 and 010FFFFC are delivered.
  - Then fetch_fault=1 with fault_pc=01100000.
- Assert reset_n=0 between clock edges with FIFO count=2:
  - inst_valid=0 and mem_address=01000000 immediately, without waiting for an edge.
